// File: rtl/select_dice_n_pkg.sv
// Shared types and helpers for the up/down index selector.
// Repeat-FSM encoding plus constant-width helpers.
package select_dice_n_pkg;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_HOLD   = 2'd1,
    RS_REPEAT = 2'd2
  } rep_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/select_dice_n_button_repeat.sv
// Press-edge detector with hold-to-auto-repeat for one button.
// step pulses on the press edge and on every repeat tick.
module button_repeat
  import select_dice_n_pkg::*;
#(
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic step
);

  localparam int CNT_W =
    clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_N  = CNT_W'(REPEAT_CYCLES);

  rep_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             prev, press, hold_done, rep_done;

  assign press     = level & ~prev;
  assign cnt_inc   = cnt + 1'b1;
  assign hold_done = (state == RS_HOLD) && (cnt_inc == HOLD_N);
  assign rep_done  = (state == RS_REPEAT) && (cnt_inc == REP_N);

  // prev resets high so a button held through reset gives no edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RS_IDLE;
      cnt   <= '0;
      prev  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= level;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!level) begin
      state_nxt = RS_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RS_IDLE: begin
          if (press && (HOLD_CYCLES != 0)) begin
            state_nxt = RS_HOLD;
            cnt_nxt   = '0;
          end
        end
        RS_HOLD: begin
          if (hold_done) begin
            state_nxt = RS_REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        RS_REPEAT: begin
          cnt_nxt = rep_done ? '0 : cnt_inc;
        end
        default: begin
          state_nxt = RS_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step = press | (level & (hold_done | rep_done));
  end

endmodule

// File: rtl/select_dice_n.sv
// Parametrised up/down index selector with wrap/saturate,
// auto-repeat and lock; drives dice type and menu indices.
module select_dice_n
  import select_dice_n_pkg::*;
#(
  parameter int NUM_CHOICES   = 8,
  parameter int SEL_W         = 3,
  parameter int DEFAULT_SEL   = 0,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             increment,
  input  logic             decrement,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CHOICES - 1);
  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(DEFAULT_SEL);

  logic             inc_step, dec_step;
  logic [SEL_W-1:0] sel_nxt;

  button_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_inc (
    .Clk  (Clk),
    .Reset(Reset),
    .level(increment),
    .step (inc_step)
  );

  button_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dec (
    .Clk  (Clk),
    .Reset(Reset),
    .level(decrement),
    .step (dec_step)
  );

  // increment has priority; a concurrent decrement is dropped
  always_comb begin
    sel_nxt = sel;
    if (!lock) begin
      if (inc_step) begin
        if (sel == MAX_SEL) sel_nxt = (WRAP != 0) ? '0 : sel;
        else                sel_nxt = sel + 1'b1;
      end else if (dec_step) begin
        if (sel == '0) sel_nxt = (WRAP != 0) ? MAX_SEL : sel;
        else           sel_nxt = sel - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel     <= RST_SEL;
      changed <= 1'b0;
    end else begin
      sel     <= sel_nxt;
      changed <= (sel_nxt != sel);
    end
  end

  assign at_min = (sel == '0);
  assign at_max = (sel == MAX_SEL);

endmodule

// File: tb/tb_select_dice_n.sv
// Scoreboard bench: two selector configs (wrap+repeat, saturate)
// checked against a cycle-count reference model.
module tb_select_dice_n;

  logic clk = 1'b0;
  logic rst, inc, dec, lck;
  logic [2:0] sel0, sel1;
  logic chg0, chg1, mn0, mn1, mx0, mx1;

  always #5 clk = ~clk;

  select_dice_n #(
    .NUM_CHOICES(6), .SEL_W(3), .DEFAULT_SEL(5), .WRAP(1),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) dut0 (
    .Clk(clk), .Reset(rst), .increment(inc), .decrement(dec),
    .lock(lck), .sel(sel0), .changed(chg0),
    .at_min(mn0), .at_max(mx0)
  );

  select_dice_n #(
    .NUM_CHOICES(6), .SEL_W(3), .DEFAULT_SEL(5), .WRAP(0),
    .HOLD_CYCLES(0), .REPEAT_CYCLES(1)
  ) dut1 (
    .Clk(clk), .Reset(rst), .increment(inc), .decrement(dec),
    .lock(lck), .sel(sel1), .changed(chg1),
    .at_min(mn1), .at_max(mx1)
  );

  typedef struct {
    int sel0;
    int sel1;
    bit chg0;
    bit chg1;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int nc[2]   = '{6, 6};
  int dflt[2] = '{5, 5};
  int wrap[2] = '{1, 0};
  int hold[2] = '{4, 0};
  int rep[2]  = '{2, 1};

  // model: per button, cycles held since the press edge (-1 = none)
  int msel[2];
  bit mchg[2];
  int mh[2][2];
  bit mprev[2][2];

  task automatic model_step();
    bit lv[2];
    bit st[2];
    int old;
    exp_t e;
    lv[0] = inc;
    lv[1] = dec;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        msel[k] = dflt[k];
        mchg[k] = 1'b0;
        for (int d = 0; d < 2; d++) begin
          mh[k][d] = -1;
          mprev[k][d] = 1'b1;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (!lv[d]) mh[k][d] = -1;
          else if (!mprev[k][d]) mh[k][d] = 0;
          else if (mh[k][d] >= 0) mh[k][d]++;
          st[d] = lv[d] && (mh[k][d] == 0 ||
                  (hold[k] > 0 && mh[k][d] >= hold[k] &&
                   (mh[k][d] - hold[k]) % rep[k] == 0));
          mprev[k][d] = lv[d];
        end
        old = msel[k];
        if (!lck && st[0]) begin
          if (wrap[k] != 0) msel[k] = (old + 1) % nc[k];
          else if (old + 1 < nc[k]) msel[k] = old + 1;
        end else if (!lck && st[1]) begin
          if (wrap[k] != 0) msel[k] = (old + nc[k] - 1) % nc[k];
          else if (old > 0) msel[k] = old - 1;
        end
        mchg[k] = (msel[k] != old);
      end
    end
    e.sel0 = msel[0];
    e.sel1 = msel[1];
    e.chg0 = mchg[0];
    e.chg1 = mchg[1];
    q.push_back(e);
  endtask

  task automatic cyc(input logic i, input logic d,
                     input logic l, input logic r);
    @(negedge clk);
    inc = i;
    dec = d;
    lck = l;
    rst = r;
    model_step();
  endtask

  task automatic run(input logic i, input logic d,
                     input logic l, input int n);
    for (int c = 0; c < n; c++) cyc(i, d, l, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sel0", 32'(sel0), 32'(e.sel0));
        chk("changed0", 32'(chg0), 32'(e.chg0));
        chk("at_min0", 32'(mn0), 32'(e.sel0 == 0));
        chk("at_max0", 32'(mx0), 32'(e.sel0 == 5));
        chk("sel1", 32'(sel1), 32'(e.sel1));
        chk("changed1", 32'(chg1), 32'(e.chg1));
        chk("at_min1", 32'(mn1), 32'(e.sel1 == 0));
        chk("at_max1", 32'(mx1), 32'(e.sel1 == 5));
      end
    end
  end

  initial begin
    logic li, ld, ll, lr;
    inc = 1'b0;
    dec = 1'b0;
    lck = 1'b0;
    rst = 1'b1;
    // reset with increment held: no step after release of reset
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    run(1, 0, 0, 6);
    run(0, 0, 0, 2);
    // wrap/saturate at max, then decrement
    run(1, 0, 0, 1);
    run(0, 0, 0, 2);
    run(0, 1, 0, 1);
    run(0, 0, 0, 2);
    // from 0 hold increment 10 cycles
    run(1, 0, 0, 1);
    run(0, 0, 0, 2);
    run(1, 0, 0, 10);
    run(0, 0, 0, 4);
    // simultaneous press from sel=3
    cyc(0, 0, 0, 1);
    run(0, 1, 0, 1);
    run(0, 0, 0, 1);
    run(0, 1, 0, 1);
    run(0, 0, 0, 1);
    run(1, 1, 0, 1);
    run(0, 0, 0, 2);
    // lock over the press edge, drop mid-hold, reset mid-repeat
    run(1, 0, 1, 2);
    run(1, 0, 0, 6);
    cyc(1, 0, 0, 1);
    run(1, 0, 0, 6);
    run(0, 0, 0, 1);
    run(1, 0, 0, 1);
    run(0, 0, 0, 2);
    // randomized phase
    li = 0; ld = 0; ll = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) li = ~li;
      if ($urandom_range(0, 5) == 0) ld = ~ld;
      if ($urandom_range(0, 9) == 0) ll = ~ll;
      lr = ($urandom_range(0, 99) == 0);
      cyc(li, ld, ll, lr);
    end
    run(0, 0, 0, 2);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
